// File: rtl/imem_boot_loader.sv
// Instruction memory with a streaming program loader and a core-reset sequencer.
// Define IMEM_CHECKSUM_EN to add a running checksum output of the loaded words.
module imem_boot_loader #(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 256,
   parameter int                ADDR_W   = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   input  logic [DATA_W-1:0]        load_data,
   input  logic                     load_last,
   output logic                     load_ready,
   input  logic                     reload,
   input  logic [ADDR_W-1:0]        fetch_addr,
   output logic [DATA_W-1:0]        fetch_data,
   output logic                     fetch_fault,
   output logic                     core_rst,
   output logic [$clog2(DEPTH):0]   load_count,
   output logic                     busy
`ifdef IMEM_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]        checksum
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W:0]     count_q, count_d;
   logic               fault_q, fault_d;
   logic               rd_ok_q;
   logic [DATA_W-1:0]  rd_q;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               accepting;
   logic               accept;
   logic               last_slot;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;

   // The word counter doubles as the write pointer; it never passes DEPTH.
   assign accepting  = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign load_ready = rst && accepting;
   assign accept     = load_valid && load_ready;
   assign wr_idx     = count_q[IDX_W-1:0];
   assign last_slot  = (count_q == (IDX_W+1)'(DEPTH - 1));
   assign rd_idx     = fetch_addr[IDX_W+1:2];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               count_d = count_q + (IDX_W+1)'(1);
               state_d = (load_last || last_slot) ? S_RELEASE : S_LOAD;
            end
         end
         S_RELEASE: state_d = S_RUN;
         S_RUN: begin
            if (reload) begin
               state_d = S_IDLE;
               count_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fault_d = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDX_W + 2)) != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         fault_q <= 1'b0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         fault_q <= fault_d;
         rd_ok_q <= 1'b1;
      end
   end

   // No reset here so the array and its read register map onto block RAM; read-first.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_idx] <= load_data;
      end
      rd_q <= mem[rd_idx];
   end

   assign fetch_data  = fault_q ? NOP_WORD : (rd_ok_q ? rd_q : '0);
   assign fetch_fault = fault_q;
   assign core_rst    = (state_q != S_RUN);
   assign busy        = (state_q == S_LOAD) || (state_q == S_RELEASE);
   assign load_count  = count_q;

`ifdef IMEM_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (accept) begin
         sum_d = sum_q + load_data;
      end else if ((state_q == S_RUN) && reload) begin
         sum_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (DEPTH=4) with a cycle-level reference model.
// Checksum checks are active only when IMEM_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 4;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic        clk        = 1'b0;
   logic        rst        = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data  = '0;
   logic        load_last  = 1'b0;
   logic        reload     = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        load_ready;
   logic [31:0] fetch_data;
   logic        fetch_fault;
   logic        core_rst;
   logic [2:0]  load_count;
   logic        busy;
`ifdef IMEM_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int tests = 0;
   int fails = 0;

   imem_boot_loader #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .NOP_WORD(NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .reload     (reload),
      .fetch_addr (fetch_addr),
      .fetch_data (fetch_data),
      .fetch_fault(fetch_fault),
      .core_rst   (core_rst),
      .load_count (load_count),
`ifdef IMEM_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words loaded so far, a pending-release flag and a running flag.
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   int          m_count = 0;
   bit          m_rel   = 1'b0;
   bit          m_run   = 1'b0;
   logic [31:0] m_sum   = '0;
   logic [31:0] e_fd    = '0;
   bit          e_ff    = 1'b0;
   bit          e_known = 1'b1;
   int          m_idx;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_count = 0;
         m_rel   = 1'b0;
         m_run   = 1'b0;
         m_sum   = '0;
         e_fd    = '0;
         e_ff    = 1'b0;
         e_known = 1'b1;
      end else begin
         if ((fetch_addr % 4) != 0 || fetch_addr >= 4 * DEPTH) begin
            e_fd    = NOP;
            e_ff    = 1'b1;
            e_known = 1'b1;
         end else begin
            m_idx   = int'(fetch_addr / 4);
            e_fd    = m_mem[m_idx];
            e_ff    = 1'b0;
            e_known = m_known[m_idx];
         end
         if (m_run) begin
            if (reload) begin
               m_run   = 1'b0;
               m_count = 0;
               m_sum   = '0;
            end
         end else if (m_rel) begin
            m_rel = 1'b0;
            m_run = 1'b1;
         end else if (load_valid) begin
            m_mem[m_count]   = load_data;
            m_known[m_count] = 1'b1;
            m_count++;
            m_sum += load_data;
            if (load_last || m_count == DEPTH) m_rel = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      check_output("load_ready", {31'b0, load_ready}, {31'b0, rst && !m_rel && !m_run});
      check_output("core_rst", {31'b0, core_rst}, {31'b0, !m_run});
      check_output("busy", {31'b0, busy}, {31'b0, m_rel || (!m_run && m_count > 0)});
      check_output("load_count", {29'b0, load_count}, 32'(m_count));
      check_output("fetch_fault", {31'b0, fetch_fault}, {31'b0, e_ff});
      if (e_known) check_output("fetch_data", fetch_data, e_fd);
`ifdef IMEM_CHECKSUM_EN
      check_output("checksum", checksum, m_sum);
`endif
   end

   task automatic apply_stimulus(input logic [31:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_load_ready", {31'b0, load_ready}, 32'd0);
      check_output("rst_core_rst", {31'b0, core_rst}, 32'd1);
      check_output("rst_fetch_data", fetch_data, 32'd0);
      check_output("rst_load_count", {29'b0, load_count}, 32'd0);
      rst = 1'b1;
      #1 check_output("idle_load_ready", {31'b0, load_ready}, 32'd1);

      apply_stimulus(32'hA, 1'b0);
      apply_stimulus(32'hB, 1'b0);
      apply_stimulus(32'hC, 1'b1);
      check_output("abc_count", {29'b0, load_count}, 32'd3);
      check_output("release_core_rst", {31'b0, core_rst}, 32'd1);
      check_output("release_ready", {31'b0, load_ready}, 32'd0);
      fetch_addr = 32'h8;
      @(negedge clk);
      check_output("run_core_rst", {31'b0, core_rst}, 32'd0);
      check_output("fetch_8", fetch_data, 32'hC);
      fetch_addr = 32'h2;
      @(negedge clk);
      check_output("misaligned_fault", {31'b0, fetch_fault}, 32'd1);
      check_output("misaligned_data", fetch_data, 32'h13);
      fetch_addr = 32'(4 * DEPTH);
      @(negedge clk);
      check_output("range_fault", {31'b0, fetch_fault}, 32'd1);
      check_output("range_data", fetch_data, 32'h13);
      fetch_addr = 32'h4;
      @(negedge clk);
      check_output("fetch_4_fault", {31'b0, fetch_fault}, 32'd0);
      check_output("fetch_4", fetch_data, 32'hB);

      pulse_reload();
      check_output("reload_core_rst", {31'b0, core_rst}, 32'd1);
      check_output("reload_count", {29'b0, load_count}, 32'd0);
      apply_stimulus(32'd1, 1'b0);
      apply_stimulus(32'd2, 1'b0);
      repeat (5) begin
         @(negedge clk);
         check_output("stall_count", {29'b0, load_count}, 32'd2);
         check_output("stall_busy", {31'b0, busy}, 32'd1);
      end
      apply_stimulus(32'd3, 1'b1);
`ifdef IMEM_CHECKSUM_EN
      check_output("checksum_6", checksum, 32'd6);
`endif
      fetch_addr = 32'h0;
      @(negedge clk);
      check_output("fetch_0_after_stall", fetch_data, 32'd1);

      pulse_reload();
      for (int i = 1; i <= 6; i++) begin
         apply_stimulus(32'h20 + 32'(i), 1'b0);
         if (i == 4) begin
            check_output("full_ready", {31'b0, load_ready}, 32'd0);
            check_output("full_count", {29'b0, load_count}, 32'd4);
         end
      end
      check_output("full_run", {31'b0, core_rst}, 32'd0);
      fetch_addr = 32'hC;
      @(negedge clk);
      check_output("fetch_c", fetch_data, 32'h24);
      apply_stimulus(32'h77, 1'b0);
      @(negedge clk);
      check_output("run_no_write", fetch_data, 32'h24);

      pulse_reload();
      fetch_addr = 32'h0;
      apply_stimulus(32'h55, 1'b0);
      check_output("read_first_old", fetch_data, 32'h21);
      reload = 1'b1;
      apply_stimulus(32'h56, 1'b0);
      reload = 1'b0;
      check_output("read_after_write", fetch_data, 32'h55);
      check_output("reload_ignored", {29'b0, load_count}, 32'd2);

      #2 rst = 1'b0;
      #1;
      check_output("abort_ready", {31'b0, load_ready}, 32'd0);
      check_output("abort_core_rst", {31'b0, core_rst}, 32'd1);
      check_output("abort_busy", {31'b0, busy}, 32'd0);
      check_output("abort_count", {29'b0, load_count}, 32'd0);
      check_output("abort_data", fetch_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      apply_stimulus(32'h11, 1'b1);
      fetch_addr = 32'h0;
      @(negedge clk);
      check_output("restart_fetch_0", fetch_data, 32'h11);
      fetch_addr = 32'h4;
      @(negedge clk);
      check_output("retained_4", fetch_data, 32'h56);
      fetch_addr = 32'h8;
      @(negedge clk);
      check_output("retained_8", fetch_data, 32'h23);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
